// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine transaction controller.
package vend_pkg;

    localparam int AMT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_e;

    localparam logic [AMT_W-1:0] COIN5_VAL  = 8'd5;
    localparam logic [AMT_W-1:0] COIN10_VAL = 8'd10;
    localparam logic [AMT_W-1:0] COIN25_VAL = 8'd25;

    localparam logic [AMT_W-1:0] PRICE [0:3] = '{8'd25, 8'd50, 8'd75, 8'd100};

    function automatic logic [AMT_W-1:0] price_of(input logic [1:0] idx);
        return PRICE[idx];
    endfunction

endpackage

// File: rtl/vend_fsm_tick_timer.sv
// 4-bit tick counter; done is a combinational pulse on the tick that reaches limit.
module tick_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [3:0] limit,
    output logic       done
);

    logic [3:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 4'd0;
        end else if (clear) begin
            count_q <= 4'd0;
        end else if (tick) begin
            count_q <= count_q + 4'd1;
        end
    end

    // clear wins, so a tick coinciding with a clear is never counted
    assign done = tick && !clear && (count_q == (limit - 4'd1));

endmodule

// File: rtl/vend_fsm.sv
// Vending transaction controller: credit accumulation, selection, timed dispense, change report.
module vend_fsm
    import vend_pkg::*;
#(
    parameter int DISP_S     = 3,
    parameter int TIMEOUT_S  = 10,
    parameter int MAX_CREDIT = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             coin5,
    input  logic             coin10,
    input  logic             coin25,
    input  logic [1:0]       sel,
    input  logic             sel_valid,
    input  logic             cancel,
    output logic [AMT_W-1:0] credit,
    output logic             dispense,
    output logic [1:0]       item,
    output logic [AMT_W-1:0] change,
    output logic             change_valid,
    output logic             coin_reject,
    output logic             insufficient,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] credit_q, credit_d;
    logic [AMT_W-1:0] change_q, change_d;
    logic [1:0]       item_q, item_d;
    logic             coin_reject_d, insufficient_d;
    logic             coin_reject_q, insufficient_q;
    logic             dispense_q, busy_q, change_valid_q;

    logic             coin_any, coin_fits, coin_ok, price_ok;
    logic [AMT_W-1:0] coin_val, price;
    logic [AMT_W:0]   coin_sum;
    logic             inact_clear, inact_done;
    logic             disp_clear, disp_done;

    assign coin_any = coin5 | coin10 | coin25;
    assign coin_val = (coin5  ? COIN5_VAL  : '0)
                    + (coin10 ? COIN10_VAL : '0)
                    + (coin25 ? COIN25_VAL : '0);
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits = (coin_sum <= (AMT_W+1)'(MAX_CREDIT));
    assign coin_ok   = coin_any && coin_fits;
    assign price     = price_of(sel);
    assign price_ok  = (credit_q >= price);

    // Activity (accepted coin or a refused selection) restarts the inactivity count.
    assign inact_clear = (state_q != ST_CREDIT) || coin_ok || (sel_valid && !price_ok);
    assign disp_clear  = (state_q != ST_DISPENSE);

    tick_timer u_inact_timer (
        .clk   (clk),
        .reset (reset),
        .clear (inact_clear),
        .tick  (tick),
        .limit (4'(TIMEOUT_S)),
        .done  (inact_done)
    );

    tick_timer u_disp_timer (
        .clk   (clk),
        .reset (reset),
        .clear (disp_clear),
        .tick  (tick),
        .limit (4'(DISP_S)),
        .done  (disp_done)
    );

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        item_d         = item_q;
        coin_reject_d  = 1'b0;
        insufficient_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (coin_any) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[AMT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_CREDIT: begin
                // Priority: cancel/timeout, then selection, then coins.
                if (cancel || inact_done) begin
                    change_d      = credit_q;
                    credit_d      = '0;
                    state_d       = ST_CHANGE;
                    coin_reject_d = coin_any;
                end else if (sel_valid && price_ok) begin
                    item_d        = sel;
                    change_d      = credit_q - price;
                    credit_d      = '0;
                    state_d       = ST_DISPENSE;
                    coin_reject_d = coin_any;
                end else begin
                    insufficient_d = sel_valid;
                    if (coin_any) begin
                        if (coin_fits) begin
                            credit_d = coin_sum[AMT_W-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_any;
                if (disp_done) begin
                    state_d = ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_any;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            item_q         <= '0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            dispense_q     <= 1'b0;
            busy_q         <= 1'b0;
            change_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            item_q         <= item_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            dispense_q     <= (state_d == ST_DISPENSE);
            busy_q         <= (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
            change_valid_q <= (state_d == ST_CHANGE);
        end
    end

    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign item         = item_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;
    assign insufficient = insufficient_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_vend_fsm.sv
// Directed bench for vend_fsm: hand-computed vectors plus a change scoreboard.
module tb_vend_fsm;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       coin5, coin10, coin25;
    logic [1:0] sel;
    logic       sel_valid;
    logic       cancel;
    logic [7:0] credit;
    logic       dispense;
    logic [1:0] item;
    logic [7:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    localparam logic [1:0] S_IDLE = 2'd0, S_CREDIT = 2'd1;

    vend_fsm #(.DISP_S(3), .TIMEOUT_S(10), .MAX_CREDIT(200)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .coin5        (coin5),
        .coin10       (coin10),
        .coin25       (coin25),
        .sel          (sel),
        .sel_valid    (sel_valid),
        .cancel       (cancel),
        .credit       (credit),
        .dispense     (dispense),
        .item         (item),
        .change       (change),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .insufficient (insufficient),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Inputs are set at a falling edge, sampled at the next rising edge,
    // and results are observed at the following falling edge.
    task automatic apply(input logic c5, input logic c10, input logic c25,
                         input logic sv, input logic [1:0] s, input logic cx, input logic tk);
        coin5 = c5; coin10 = c10; coin25 = c25;
        sel_valid = sv; sel = s; cancel = cx; tick = tk;
        @(negedge clk);
        coin5 = 0; coin10 = 0; coin25 = 0; sel_valid = 0; sel = 0; cancel = 0; tick = 0;
    endtask

    task automatic put25(); apply(0, 0, 1, 0, 2'd0, 0, 0); endtask
    task automatic put10(); apply(0, 1, 0, 0, 2'd0, 0, 0); endtask
    task automatic put5();  apply(1, 0, 0, 0, 2'd0, 0, 0); endtask
    task automatic pick(input logic [1:0] s); apply(0, 0, 0, 1, s, 0, 0); endtask
    task automatic do_tick(); apply(0, 0, 0, 0, 2'd0, 0, 1); endtask
    task automatic idle(); apply(0, 0, 0, 0, 2'd0, 0, 0); endtask

    // Change scoreboard: every change_valid must match the oldest expected amount.
    always @(negedge clk) begin
        if (!reset && change_valid) begin
            check("chg_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("chg_amount", change, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1; tick = 0; coin5 = 0; coin10 = 0; coin25 = 0;
        sel = 0; sel_valid = 0; cancel = 0;
        repeat (2) @(negedge clk);
        check("rst_credit", credit, 0);
        check("rst_dispense", dispense, 0);
        check("rst_busy", busy, 0);
        check("rst_chg_valid", change_valid, 0);
        check("rst_state", state_dbg, S_IDLE);
        reset = 0;
        @(negedge clk);

        // Exact price
        pick(2'd1);
        check("idle_sel_ignored", state_dbg, S_IDLE);
        put25(); put25(); put25();
        check("exact_credit", credit, 75);
        check("exact_state", state_dbg, S_CREDIT);
        exp_q.push_back(8'd0);
        pick(2'd2);
        check("exact_dispense", dispense, 1);
        check("exact_item", item, 2);
        check("exact_busy", busy, 1);
        check("exact_credit_clr", credit, 0);
        do_tick(); do_tick();
        check("exact_hold_2t", dispense, 1);
        do_tick();
        check("exact_chg_valid", change_valid, 1);
        check("exact_change", change, 0);
        check("exact_disp_off", dispense, 0);
        check("exact_busy_chg", busy, 1);
        idle();
        check("exact_idle", state_dbg, S_IDLE);
        check("exact_busy_off", busy, 0);
        check("exact_cv_pulse", change_valid, 0);

        // Overpay; tick coinciding with selection must not count
        put25(); put25(); put25(); put25(); put10();
        check("over_credit", credit, 110);
        exp_q.push_back(8'd85);
        apply(0, 0, 0, 1, 2'd0, 0, 1);
        check("over_dispense", dispense, 1);
        check("over_item", item, 0);
        put10();
        check("disp_coin_reject", coin_reject, 1);
        check("disp_coin_credit", credit, 0);
        do_tick(); do_tick();
        check("over_entry_tick", dispense, 1);
        do_tick();
        check("over_chg_valid", change_valid, 1);
        check("over_change", change, 85);
        idle();

        // Insufficient, then top-up
        put10();
        pick(2'd1);
        check("insuf_pulse", insufficient, 1);
        check("insuf_credit", credit, 10);
        check("insuf_state", state_dbg, S_CREDIT);
        idle();
        check("insuf_pulse_end", insufficient, 0);
        put25(); put25();
        check("topup_credit", credit, 60);
        exp_q.push_back(8'd10);
        pick(2'd1);
        check("topup_dispense", dispense, 1);
        check("topup_item", item, 1);
        do_tick(); do_tick(); do_tick();
        check("topup_chg_valid", change_valid, 1);
        idle();

        // Simultaneous coins and saturation
        repeat (7) put25();
        put10(); put5();
        check("sat_credit_190", credit, 190);
        apply(1, 1, 1, 0, 2'd0, 0, 0);
        check("sat_reject", coin_reject, 1);
        check("sat_credit_kept", credit, 190);
        put10();
        check("sat_credit_200", credit, 200);
        check("sat_no_reject", coin_reject, 0);
        exp_q.push_back(8'd200);
        apply(0, 0, 0, 0, 2'd0, 1, 0);
        check("sat_cancel_cv", change_valid, 1);
        idle();

        // Inactivity timeout
        put5();
        repeat (9) begin do_tick(); idle(); end
        check("to_9_state", state_dbg, S_CREDIT);
        check("to_9_credit", credit, 5);
        exp_q.push_back(8'd5);
        do_tick();
        check("to_10_cv", change_valid, 1);
        check("to_10_change", change, 5);
        check("to_10_credit", credit, 0);
        idle();

        // Cancel beats selection and coin in the same cycle
        put25();
        exp_q.push_back(8'd25);
        apply(1, 0, 0, 1, 2'd0, 1, 0);
        check("cx_cv", change_valid, 1);
        check("cx_change", change, 25);
        check("cx_no_dispense", dispense, 0);
        check("cx_coin_reject", coin_reject, 1);
        check("cx_no_insuf", insufficient, 0);
        idle();
        check("cx_idle", state_dbg, S_IDLE);

        // Reset mid-dispense
        put25();
        pick(2'd0);
        check("rd_dispense", dispense, 1);
        do_tick();
        #2 reset = 1;
        #1;
        check("rd_disp_drop", dispense, 0);
        check("rd_busy_drop", busy, 0);
        check("rd_state", state_dbg, S_IDLE);
        @(negedge clk);
        reset = 0;
        repeat (4) begin
            do_tick();
            check("rd_no_cv", change_valid, 0);
        end
        check("rd_credit", credit, 0);
        check("rd_idle", state_dbg, S_IDLE);
        check("chg_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
